// File: rtl/bbb_spi_model.sv
// bbb_spi_model: mode-0 SPI master standing in for the flight computer, sending command/address/data frames.
// Optional macro BBB_SPI_SS_PER_WORD_EN raises slave select during every inter-word gap.
module bbb_spi_model #(
   parameter int HALF_CYC = 8,
   parameter int GAP_CYC  = 16
) (
   input  logic        clk210_p,
   input  logic        reset_p,
   input  logic        spi_initial,
   input  logic [15:0] spi_command_p,
   input  logic [15:0] spi_wr_addr_p,
   input  logic [15:0] spi_wr_data_p,
   input  logic [15:0] spi_rd_addr_p,
   input  logic        spi_miso_p,
   output logic        spi_mosi_p,
   output logic        spi_sck_p,
   output logic        spi_ss_p,
   output logic [7:0]  spi_state_s,
   output logic [15:0] spi_rd_data_s
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

`ifdef BBB_SPI_SS_PER_WORD_EN
   localparam logic GAP_SS = 1'b1;
`else
   localparam logic GAP_SS = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        sck_q, sck_d;
   logic [4:0]  bit_q, bit_d;
   logic [1:0]  word_q, word_d;
   logic [47:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic        rd_cmd_q, rd_cmd_d;
   logic [15:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk210_p) begin
      if (!reset_p) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sck_q     <= 1'b0;
         bit_q     <= '0;
         word_q    <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rd_cmd_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sck_q     <= sck_d;
         bit_q     <= bit_d;
         word_q    <= word_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rd_cmd_q  <= rd_cmd_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      sck_d     = sck_q;
      bit_d     = bit_q;
      word_d    = word_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rd_cmd_d  = rd_cmd_q;
      rd_data_d = rd_data_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            sck_d = 1'b0;
            if (spi_initial) begin
               state_d  = ST_SETUP;
               bit_d    = '0;
               word_d   = '0;
               rd_cmd_d = (spi_command_p == 16'd3);
               if (spi_command_p == 16'd3)
                  tx_d = {spi_command_p, spi_rd_addr_p, 16'h0000};
               else
                  tx_d = {spi_command_p, spi_wr_addr_p, spi_wr_data_p};
            end
         end
         ST_SETUP: begin
            if (cnt_q == HALF_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         end
         // Each bit is a low half then a high half; a 17th low half closes the word.
         ST_SHIFT: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (sck_q) begin
                  sck_d = 1'b0;
                  tx_d  = {tx_q[46:0], 1'b0};
                  bit_d = bit_q + 5'd1;
               end else if (bit_q == 5'd16) begin
                  bit_d = '0;
                  if (word_q == 2'd2) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_GAP;
                     word_d  = word_q + 2'd1;
                  end
               end else begin
                  sck_d = 1'b1;
                  rx_d  = {rx_q[14:0], spi_miso_p};
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            if (cnt_q == HALF_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (rd_cmd_q)
                  rd_data_d = rx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign spi_sck_p     = sck_q;
   assign spi_mosi_p    = (state_q == ST_IDLE) ? 1'b0 : tx_q[47];
   assign spi_ss_p      = (state_q == ST_IDLE) | ((state_q == ST_GAP) & GAP_SS);
   assign spi_state_s   = {5'd0, state_q};
   assign spi_rd_data_s = rd_data_q;

endmodule

// File: tb/tb_bbb_spi_model.sv
// Scoreboard bench for bbb_spi_model: random and directed frames checked against a frame-level model.
// Honours BBB_SPI_SS_PER_WORD_EN for the expected slave-select level during gaps.
module tb_bbb_spi_model;

   localparam int H = 8;
   localparam int G = 16;
   localparam int FRAME_LEN = H + 3 * (33 * H) + 2 * G + H;

`ifdef BBB_SPI_SS_PER_WORD_EN
   localparam logic GAP_SS = 1'b1;
`else
   localparam logic GAP_SS = 1'b0;
`endif

   typedef struct {
      logic [47:0] bits;
      logic [15:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_p;
   logic        spi_initial;
   logic [15:0] spi_command_p, spi_wr_addr_p, spi_wr_data_p, spi_rd_addr_p;
   logic        spi_miso_p;
   logic        spi_mosi_p, spi_sck_p, spi_ss_p;
   logic [7:0]  spi_state_s;
   logic [15:0] spi_rd_data_s;

   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   logic [15:0] model_rd = 16'h0000;
   logic [15:0] slave_word = 16'h0000;

   bbb_spi_model #(.HALF_CYC(H), .GAP_CYC(G)) dut (
      .clk210_p      (clk),
      .reset_p       (reset_p),
      .spi_initial   (spi_initial),
      .spi_command_p (spi_command_p),
      .spi_wr_addr_p (spi_wr_addr_p),
      .spi_wr_data_p (spi_wr_data_p),
      .spi_rd_addr_p (spi_rd_addr_p),
      .spi_miso_p    (spi_miso_p),
      .spi_mosi_p    (spi_mosi_p),
      .spi_sck_p     (spi_sck_p),
      .spi_ss_p      (spi_ss_p),
      .spi_state_s   (spi_state_s),
      .spi_rd_data_s (spi_rd_data_s)
   );

   always #2 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Slave: presents bit i after the SCK fall that follows rise i; only word2 carries real data.
   int   s_rises = 0;
   logic s_prev_sck = 1'b0;
   always @(negedge clk) begin
      if (!reset_p || spi_state_s == 8'd0) begin
         s_rises    = 0;
         spi_miso_p = 1'($urandom);
      end else if (spi_sck_p && !s_prev_sck) begin
         s_rises++;
      end else if (!spi_sck_p && s_prev_sck) begin
         if (s_rises >= 32 && s_rises < 48)
            spi_miso_p = slave_word[47 - s_rises];
         else
            spi_miso_p = 1'($urandom);
      end
      s_prev_sck = spi_sck_p;
   end

   // Monitor: gathers one frame of bus activity and compares it with the oldest expectation.
   bit          in_frame = 1'b0;
   int          cyc, rises, first_rise, gap_cyc, ss_bad;
   logic [47:0] got_bits;
   logic        m_prev_sck = 1'b0;
   exp_t        cur;
   always @(negedge clk) begin
      if (!reset_p) begin
         in_frame = 1'b0;
      end else if (spi_state_s != 8'd0) begin
         if (!in_frame) begin
            in_frame   = 1'b1;
            cyc        = 0;
            rises      = 0;
            first_rise = 0;
            gap_cyc    = 0;
            ss_bad     = 0;
            got_bits   = '0;
         end
         cyc++;
         if (spi_sck_p && !m_prev_sck) begin
            rises++;
            got_bits = {got_bits[46:0], spi_mosi_p};
            if (rises == 1)
               first_rise = cyc;
         end
         if (spi_state_s == 8'd3) begin
            gap_cyc++;
            if (spi_ss_p !== GAP_SS)
               ss_bad++;
         end else if (spi_ss_p !== 1'b0) begin
            ss_bad++;
         end
      end else if (in_frame) begin
         in_frame = 1'b0;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_frame", 64'd1, 64'd0);
         end else begin
            cur = exp_q.pop_front();
            checkOutput("mosi_word0", {48'd0, got_bits[47:32]}, {48'd0, cur.bits[47:32]});
            checkOutput("mosi_word1", {48'd0, got_bits[31:16]}, {48'd0, cur.bits[31:16]});
            checkOutput("mosi_word2", {48'd0, got_bits[15:0]}, {48'd0, cur.bits[15:0]});
            checkOutput("rd_data", {48'd0, spi_rd_data_s}, {48'd0, cur.rd});
         end
         checkOutput("sck_rises", 64'(rises), 64'd48);
         checkOutput("frame_len", 64'(cyc), 64'(FRAME_LEN));
         checkOutput("first_rise", 64'(first_rise), 64'(2 * H + 1));
         checkOutput("gap_cycles", 64'(gap_cyc), 64'(2 * G));
         checkOutput("ss_violations", 64'(ss_bad), 64'd0);
         checkOutput("ss_idle", {63'd0, spi_ss_p}, 64'd1);
      end
      m_prev_sck = spi_sck_p;
   end

   task automatic waitIdle();
      int n = 0;
      @(posedge clk); #1;
      while (spi_state_s != 8'd0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000)
         checkOutput("idle_timeout", 64'd1, 64'd0);
   endtask

   // mode 0: plain frame, 1: ignored start pulse mid-frame, 2: reset during word1
   task automatic applyStimulus(input logic [15:0] cmd, input logic [15:0] wa, input logic [15:0] wd,
                                input logic [15:0] ra, input logic [15:0] slv, input int mode);
      exp_t e;
      waitIdle();
      spi_command_p = cmd;
      spi_wr_addr_p = wa;
      spi_wr_data_p = wd;
      spi_rd_addr_p = ra;
      slave_word    = slv;
      spi_initial   = 1'b1;
      e.bits = (cmd == 16'd3) ? {cmd, ra, 16'h0000} : {cmd, wa, wd};
      e.rd   = (cmd == 16'd3) ? slv : model_rd;
      exp_q.push_back(e);
      if (mode != 2)
         model_rd = e.rd;
      @(posedge clk); #1;
      spi_initial   = 1'b0;
      spi_command_p = 16'($urandom);
      spi_wr_addr_p = 16'($urandom);
      spi_wr_data_p = 16'($urandom);
      spi_rd_addr_p = 16'($urandom);
      if (mode == 1) begin
         repeat (300) @(posedge clk);
         #1;
         spi_command_p = 16'd3;
         spi_initial   = 1'b1;
         @(posedge clk); #1;
         spi_initial   = 1'b0;
      end else if (mode == 2) begin
         repeat (400) @(posedge clk);
         #1;
         reset_p = 1'b0;
         @(posedge clk); #1;
         checkOutput("rst_mid_ss", {63'd0, spi_ss_p}, 64'd1);
         checkOutput("rst_mid_sck", {63'd0, spi_sck_p}, 64'd0);
         checkOutput("rst_mid_state", {56'd0, spi_state_s}, 64'd0);
         checkOutput("rst_mid_rd", {48'd0, spi_rd_data_s}, 64'd0);
         reset_p = 1'b1;
         void'(exp_q.pop_back());
         model_rd = 16'h0000;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] c;
      int r;
      reset_p       = 1'b0;
      spi_initial   = 1'b0;
      spi_command_p = '0;
      spi_wr_addr_p = '0;
      spi_wr_data_p = '0;
      spi_rd_addr_p = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ss", {63'd0, spi_ss_p}, 64'd1);
      checkOutput("reset_sck", {63'd0, spi_sck_p}, 64'd0);
      checkOutput("reset_mosi", {63'd0, spi_mosi_p}, 64'd0);
      checkOutput("reset_state", {56'd0, spi_state_s}, 64'd0);
      checkOutput("reset_rd", {48'd0, spi_rd_data_s}, 64'd0);
      reset_p = 1'b1;
      $display("[TB] directed frames");
      applyStimulus(16'd2, 16'h0050, 16'h0011, 16'h7777, 16'hBEEF, 0);
      applyStimulus(16'd3, 16'h9999, 16'h8888, 16'h0051, 16'h0011, 0);
      applyStimulus(16'd3, 16'h1234, 16'h4321, 16'h0020, 16'hC3A5, 0);
      applyStimulus(16'd5, 16'hAAAA, 16'h5555, 16'h0F0F, 16'h1357, 0);
      applyStimulus(16'd3, 16'h0001, 16'h0002, 16'h00A0, 16'h6E2B, 1);
      applyStimulus(16'd2, 16'h0040, 16'h00FF, 16'h0041, 16'h2222, 2);
      applyStimulus(16'd3, 16'h0000, 16'h0000, 16'h0051, 16'hA55A, 0);
      $display("[TB] random frames");
      for (int i = 0; i < 8; i++) begin
         r = $urandom_range(0, 3);
         c = (r == 0) ? 16'd2 : (r == 1) ? 16'd3 : (r == 2) ? 16'd5 : 16'($urandom);
         applyStimulus(c, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0);
      end
      waitIdle();
      repeat (5) @(posedge clk);
      #1;
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
